// File: rtl/weight_loader.sv
// Streams DDR weight beats into BUFFER_NUM banks, one row at a time. Each beat
// covers BANKS_PER_BEAT adjacent banks, and BEATS_PER_ROW beats fill one row.
module weight_loader #(
   parameter int ADDR_LEN     = 16,
   parameter int DATA_LEN     = 64,
   parameter int DDR_DATA_LEN = 256,
   parameter int BUFFER_NUM   = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    cfg_start,
   input  logic [ADDR_LEN-1:0]     cfg_base_addr,
   input  logic [ADDR_LEN-1:0]     cfg_rows,
   input  logic [DDR_DATA_LEN-1:0] ddr_data,
   input  logic                    ddr_valid,
   output logic                    ddr_ready,
   output logic [DDR_DATA_LEN-1:0] data_wr,
   output logic [ADDR_LEN-1:0]     wr_addr,
   output logic [BUFFER_NUM-1:0]   wr_en,
   output logic                    busy,
   output logic                    done
);

   localparam int BANKS_PER_BEAT = DDR_DATA_LEN / DATA_LEN;
   localparam int BEATS_PER_ROW  = BUFFER_NUM / BANKS_PER_BEAT;
   localparam int BEAT_W         = (BEATS_PER_ROW > 1) ? $clog2(BEATS_PER_ROW) : 1;
   localparam logic [BEAT_W-1:0]   LAST_BEAT = BEAT_W'(BEATS_PER_ROW - 1);
   localparam logic [ADDR_LEN-1:0] ONE_ROW   = ADDR_LEN'(1);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      DONE
   } state_t;

   state_t                  state_q,    state_d;
   logic [ADDR_LEN-1:0]     row_ptr_q,  row_ptr_d;
   logic [ADDR_LEN-1:0]     row_cnt_q,  row_cnt_d;
   logic [BEAT_W-1:0]       beat_cnt_q, beat_cnt_d;
   logic [DDR_DATA_LEN-1:0] data_wr_q,  data_wr_d;
   logic [ADDR_LEN-1:0]     wr_addr_q,  wr_addr_d;
   logic [BUFFER_NUM-1:0]   wr_en_q,    wr_en_d;
   logic                    accept;

   always_comb begin
      state_d    = state_q;
      row_ptr_d  = row_ptr_q;
      row_cnt_d  = row_cnt_q;
      beat_cnt_d = beat_cnt_q;
      data_wr_d  = data_wr_q;
      wr_addr_d  = wr_addr_q;
      wr_en_d    = '0;
      accept     = (state_q == LOAD) && ddr_valid;

      unique case (state_q)
         IDLE: begin
            if (cfg_start) begin
               row_ptr_d  = cfg_base_addr;
               row_cnt_d  = cfg_rows;
               beat_cnt_d = '0;
               state_d    = (cfg_rows != '0) ? LOAD : DONE;
            end
         end
         LOAD: begin
            if (accept) begin
               data_wr_d = ddr_data;
               wr_addr_d = row_ptr_q;
               // Bank group index of each enable bit selects the beat it belongs to.
               for (int unsigned i = 0; i < BUFFER_NUM; i++) begin
                  wr_en_d[i] = (BEAT_W'(i / BANKS_PER_BEAT) == beat_cnt_q);
               end
               if (beat_cnt_q == LAST_BEAT) begin
                  beat_cnt_d = '0;
                  row_ptr_d  = row_ptr_q + ONE_ROW;
                  row_cnt_d  = row_cnt_q - ONE_ROW;
                  if (row_cnt_q == ONE_ROW) begin
                     state_d = DONE;
                  end
               end else begin
                  beat_cnt_d = beat_cnt_q + BEAT_W'(1);
               end
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         row_ptr_q  <= '0;
         row_cnt_q  <= '0;
         beat_cnt_q <= '0;
         data_wr_q  <= '0;
         wr_addr_q  <= '0;
         wr_en_q    <= '0;
      end else begin
         state_q    <= state_d;
         row_ptr_q  <= row_ptr_d;
         row_cnt_q  <= row_cnt_d;
         beat_cnt_q <= beat_cnt_d;
         data_wr_q  <= data_wr_d;
         wr_addr_q  <= wr_addr_d;
         wr_en_q    <= wr_en_d;
      end
   end

   assign ddr_ready = (state_q == LOAD);
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
   assign data_wr   = data_wr_q;
   assign wr_addr   = wr_addr_q;
   assign wr_en     = wr_en_q;

endmodule

// File: tb/tb_weight_loader.sv
// Scoreboard bench for weight_loader: each driven beat queues its expected bank
// write, and a negedge monitor pops and compares every wr_en pulse.
module tb_weight_loader;

   logic         clk;
   logic         rst_n;
   logic         cfg_start;
   logic [15:0]  cfg_base_addr;
   logic [15:0]  cfg_rows;
   logic [255:0] ddr_data;
   logic         ddr_valid;
   logic         ddr_ready;
   logic [255:0] data_wr;
   logic [15:0]  wr_addr;
   logic [31:0]  wr_en;
   logic         busy;
   logic         done;

   typedef struct {
      logic [15:0]  addr;
      logic [31:0]  en;
      logic [255:0] data;
      logic         last;
   } sb_entry_t;

   sb_entry_t sb[$];
   sb_entry_t mon_e;
   int        n_tests  = 0;
   int        n_fail   = 0;
   int        done_cnt = 0;
   int        d0;

   weight_loader #(
      .ADDR_LEN    (16),
      .DATA_LEN    (64),
      .DDR_DATA_LEN(256),
      .BUFFER_NUM  (32)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cfg_start    (cfg_start),
      .cfg_base_addr(cfg_base_addr),
      .cfg_rows     (cfg_rows),
      .ddr_data     (ddr_data),
      .ddr_valid    (ddr_valid),
      .ddr_ready    (ddr_ready),
      .data_wr      (data_wr),
      .wr_addr      (wr_addr),
      .wr_en        (wr_en),
      .busy         (busy),
      .done         (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] gen_data();
      logic [255:0] d;
      for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   always @(negedge clk) begin
      if (wr_en !== '0) begin
         if (sb.size() == 0) begin
            check_eq("unexpected_wr_en", wr_en, 0);
         end else begin
            mon_e = sb.pop_front();
            check_eq("wr_addr", wr_addr, mon_e.addr);
            check_eq("wr_en", wr_en, mon_e.en);
            check_eq("data_wr", data_wr, mon_e.data);
            check_eq("done_with_wr", done, mon_e.last);
         end
      end
      if (done === 1'b1) done_cnt++;
   end

   // Starts a load and drives up to max_beats beats; returns on the negedge
   // right after the final accept. inject = beat index carrying a stray cfg_start.
   task automatic run_load(input logic [15:0] base, input logic [15:0] rows,
                           input bit gap, input int max_beats, input int inject);
      sb_entry_t e;
      int        n;
      int        nrows;
      n     = 0;
      nrows = int'(rows);
      @(negedge clk);
      cfg_start     = 1'b1;
      cfg_base_addr = base;
      cfg_rows      = rows;
      @(negedge clk);
      cfg_start = 1'b0;
      check_eq("ready_in_load", ddr_ready, 1);
      for (int r = 0; r < nrows && n < max_beats; r++) begin
         for (int b = 0; b < 8 && n < max_beats; b++) begin
            if (gap && n > 0) begin
               ddr_data = gen_data();
               @(negedge clk);
            end
            e.addr = base + 16'(r);
            e.en   = 32'hF << (4 * b);
            e.data = gen_data();
            e.last = (b == 7) && (r == nrows - 1);
            ddr_valid = 1'b1;
            ddr_data  = e.data;
            sb.push_back(e);
            if (n == inject) begin
               cfg_start     = 1'b1;
               cfg_base_addr = 16'h0200;
               cfg_rows      = 16'd5;
            end
            n++;
            @(negedge clk);
            cfg_start = 1'b0;
            ddr_valid = 1'b0;
         end
      end
      ddr_valid = 1'b0;
   endtask

   task automatic finish_load(input int done_before);
      #1;
      check_eq("ready_after_last", ddr_ready, 0);
      check_eq("busy_in_done", busy, 1);
      @(negedge clk);
      #1;
      check_eq("busy_idle", busy, 0);
      check_eq("done_low", done, 0);
      check_eq("sb_empty", sb.size(), 0);
      check_eq("done_count", done_cnt, done_before + 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n         = 1'b0;
      cfg_start     = 1'b0;
      cfg_base_addr = '0;
      cfg_rows      = '0;
      ddr_data      = '0;
      ddr_valid     = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check_eq("rst_wr_en", wr_en, 0);
      check_eq("rst_data_wr", data_wr, 0);
      check_eq("rst_wr_addr", wr_addr, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_ready", ddr_ready, 0);
      rst_n = 1'b1;

      // Single row, back-to-back beats.
      d0 = done_cnt;
      run_load(16'h0010, 16'd1, 1'b0, 8, -1);
      finish_load(d0);

      // Valid toggling every cycle over two rows.
      d0 = done_cnt;
      run_load(16'h0020, 16'd2, 1'b1, 16, -1);
      finish_load(d0);

      // Row pointer wraps past the top of the address space.
      d0 = done_cnt;
      run_load(16'hFFFF, 16'd2, 1'b0, 16, -1);
      finish_load(d0);

      // Zero rows: straight to DONE, valid beats ignored.
      d0 = done_cnt;
      @(negedge clk);
      cfg_start     = 1'b1;
      cfg_base_addr = 16'h0030;
      cfg_rows      = 16'd0;
      ddr_valid     = 1'b1;
      ddr_data      = gen_data();
      @(negedge clk);
      cfg_start = 1'b0;
      #1;
      check_eq("zero_done", done, 1);
      check_eq("zero_busy", busy, 1);
      check_eq("zero_ready", ddr_ready, 0);
      check_eq("zero_wr_en", wr_en, 0);
      @(negedge clk);
      #1;
      check_eq("zero_done_end", done, 0);
      check_eq("zero_busy_end", busy, 0);
      check_eq("zero_ready_end", ddr_ready, 0);
      ddr_valid = 1'b0;
      check_eq("zero_done_count", done_cnt, d0 + 1);

      // Reset after the third beat, with a start in the same cycle as reset.
      @(negedge clk);
      d0 = done_cnt;
      run_load(16'h0400, 16'd4, 1'b0, 3, -1);
      rst_n         = 1'b0;
      cfg_start     = 1'b1;
      cfg_base_addr = 16'h0500;
      cfg_rows      = 16'd1;
      ddr_valid     = 1'b1;
      ddr_data      = gen_data();
      @(negedge clk);
      #1;
      check_eq("mid_rst_wr_en", wr_en, 0);
      check_eq("mid_rst_data_wr", data_wr, 0);
      check_eq("mid_rst_wr_addr", wr_addr, 0);
      check_eq("mid_rst_busy", busy, 0);
      check_eq("mid_rst_done", done, 0);
      check_eq("mid_rst_ready", ddr_ready, 0);
      rst_n     = 1'b1;
      cfg_start = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check_eq("post_rst_busy", busy, 0);
      check_eq("post_rst_ready", ddr_ready, 0);
      ddr_valid = 1'b0;
      check_eq("post_rst_sb_empty", sb.size(), 0);
      check_eq("post_rst_no_done", done_cnt, d0);
      run_load(16'h0100, 16'd1, 1'b0, 8, -1);
      finish_load(d0);

      // Stray start during LOAD must not disturb the running load.
      @(negedge clk);
      d0 = done_cnt;
      run_load(16'h0300, 16'd1, 1'b0, 8, 2);
      finish_load(d0);

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/weight_loader.md
WEIGHT_LOADER -- requirements
Module: weight_loader

Interface
REQ-001 SHALL have parameter ADDR_LEN, default 16, the weight-bank address width.
REQ-002 SHALL have parameter DATA_LEN, default 64, the width of one bank word.
REQ-003 SHALL have parameter DDR_DATA_LEN, default 256, the width of one DDR beat.
REQ-004 SHALL have parameter BUFFER_NUM, default 32, the number of weight banks.
REQ-005 SHALL derive BANKS_PER_BEAT = DDR_DATA_LEN/DATA_LEN (4) and BEATS_PER_ROW = BUFFER_NUM/BANKS_PER_BEAT (8).
REQ-006 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst_n, input, 1, a synchronous active-low reset.
REQ-008 SHALL have port cfg_start, input, 1, a one-cycle load request.
REQ-009 SHALL have port cfg_base_addr, input, ADDR_LEN, the first bank row address.
REQ-010 SHALL have port cfg_rows, input, ADDR_LEN, the number of bank rows to fill.
REQ-011 SHALL have port ddr_data, input, DDR_DATA_LEN, the DDR weight beat.
REQ-012 SHALL have port ddr_valid, input, 1, which indicates that ddr_data is valid.
REQ-013 SHALL have port ddr_ready, output, 1, the beat-accept indication.
REQ-014 SHALL have port data_wr, output, DDR_DATA_LEN, the beat data that is broadcast to the banks.
REQ-015 SHALL have port wr_addr, output, ADDR_LEN, the bank row address.
REQ-016 SHALL have port wr_en, output, BUFFER_NUM, the per-bank write enables.
REQ-017 SHALL have port busy, output, 1, which is high when the state is not IDLE.
REQ-018 SHALL have port done, output, 1, a one-cycle pulse at the end of a load.

Function
REQ-019 SHALL implement the states IDLE, LOAD and DONE.
REQ-020 In IDLE, cfg_start=1 SHALL cause the block to:
  - latch cfg_base_addr into the row pointer;
  - latch cfg_rows into the row counter;
  - clear the beat counter;
  - go to LOAD if cfg_rows is nonzero, otherwise go to DONE.
REQ-021 cfg_start SHALL be ignored in LOAD and in DONE.
REQ-022 ddr_ready SHALL equal (state==LOAD) and SHALL be decoded directly from the state register.
REQ-023 A beat SHALL be accepted only on a cycle where ddr_valid and ddr_ready are both 1.
REQ-024 On the cycle after an accept, the outputs SHALL be:
  - data_wr = the accepted ddr_data;
  - wr_addr = the current row pointer;
  - wr_en = {BANKS_PER_BEAT{1'b1}} << (BANKS_PER_BEAT*beat_cnt).
REQ-025 Write latency SHALL be exactly 1 cycle from accept to wr_en.
REQ-026 On any cycle without an accept, wr_en SHALL be 0, while data_wr and wr_addr hold their previous values.
REQ-027 beat_cnt SHALL increment on each accept and wrap from BEATS_PER_ROW-1 to 0.
REQ-028 When beat_cnt wraps, the row pointer SHALL increment and the row counter SHALL decrement.
REQ-029 The row pointer SHALL wrap modulo 2^ADDR_LEN (0xFFFF+1 -> 0x0000).
REQ-030 An accept with beat_cnt==BEATS_PER_ROW-1 and row counter==1 SHALL move the state to DONE, so ddr_ready is 0 on the following cycle.
REQ-031 DONE SHALL last exactly 1 cycle, with done=1 in that cycle, and SHALL then return to IDLE.
REQ-032 In DONE, the final row's wr_en (bits [BUFFER_NUM-1:BUFFER_NUM-BANKS_PER_BEAT]) SHALL coincide with done=1.
REQ-033 ddr_valid=0 in LOAD SHALL stall the load with no writes and no state change, for any number of cycles.
REQ-034 ddr_valid=1 outside LOAD SHALL have no effect.
REQ-035 A load of N rows SHALL produce exactly N*BEATS_PER_ROW wr_en pulses, with every bank written exactly once per row.

Reset
REQ-036 rst_n=0 sampled at a clock edge SHALL force:
  - state IDLE;
  - data_wr, wr_addr and wr_en to 0;
  - done=0, busy=0, ddr_ready=0;
  - all counters to 0.
REQ-037 Reset asserted during LOAD SHALL abort the load with no done pulse, and any later beats SHALL not be accepted until a new cfg_start.
REQ-038 cfg_start asserted in the same cycle as rst_n=0 SHALL be ignored.

Verification
REQ-039 Single row:
  - stimulus: base=0x0010, rows=1, eight back-to-back valid beats D0..D7;
  - response: wr_addr=0x0010 throughout, wr_en=0x0000000F, 0x000000F0, ..., 0xF0000000 on consecutive cycles, data_wr=Dk;
  - response: done is high with the last wr_en, and ddr_ready is low the cycle after the 8th accept.
REQ-040 Stalls:
  - stimulus: rows=2, ddr_valid toggling 1/0 every cycle;
  - response: 16 wr_en pulses total, none during invalid cycles;
  - response: wr_addr = base for pulses 1-8 and base+1 for pulses 9-16;
  - response: done occurs exactly once.
REQ-041 Address wrap:
  - stimulus: base=0xFFFF, rows=2;
  - response: the first row is written at 0xFFFF and the second at 0x0000.
REQ-042 Zero rows:
  - stimulus: rows=0 with cfg_start;
  - response: DONE on the next cycle, done=1 for 1 cycle, wr_en always 0, ddr_ready never 1.
REQ-043 Reset mid-load:
  - stimulus: rst_n=0 after the 3rd beat of rows=4;
  - response: all outputs are 0 on the next cycle, with no done;
  - response: a new start with base=0x0100 then writes its first beat at 0x0100 with wr_en=0x0000000F.
REQ-044 Ignored start:
  - stimulus: cfg_start with base=0x0200 while in LOAD;
  - response: the load continues at the original addresses unaffected.
